// File: rtl/misr_signature_analyzer.sv
// Multiple-input signature register for BIST response compaction.
// Folds N_PATTERNS CUT responses into a signature, then compares it against
// a golden value once and reports done/pass until restarted or aborted.
module misr_signature_analyzer #(
    parameter int unsigned    W          = 16,
    parameter logic [W-1:0]   POLY       = 16'h100B,
    parameter logic [W-1:0]   SEED       = '0,
    parameter int unsigned    N_PATTERNS = 64,
    localparam int unsigned   CW         = $clog2(N_PATTERNS + 1)
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          start,
    input  logic          abort,
    input  logic          in_valid,
    input  logic [W-1:0]  in_data,
    input  logic [W-1:0]  golden,
    output logic [W-1:0]  signature,
    output logic [CW-1:0] count,
    output logic          busy,
    output logic          done,
    output logic          pass
);

    typedef enum logic [1:0] {IDLE, RUN, CHECK, DONE} state_t;

    // Count value at which the next accepted response is the final one.
    localparam logic [CW-1:0] LAST = CW'(N_PATTERNS - 1);

    state_t        state_q, state_d;
    logic [W-1:0]  sig_q, sig_d, sig_next;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          pass_q, pass_d;
    logic          fb;

    // MISR step: tap-masked parity shifts in at the MSB, response XORed in.
    assign fb       = ^(sig_q & POLY);
    assign sig_next = {fb, sig_q[W-1:1]} ^ in_data;

    // Session sequencing; abort overrides everything, including start.
    always_comb begin
        state_d = state_q;
        sig_d   = sig_q;
        cnt_d   = cnt_q;
        done_d  = done_q;
        pass_d  = pass_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    sig_d   = SEED;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (in_valid) begin
                    sig_d = sig_next;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == LAST) state_d = CHECK;
                end
            end
            CHECK: begin
                pass_d  = (sig_q == golden);
                done_d  = 1'b1;
                state_d = DONE;
            end
            DONE: begin
                if (start) begin
                    done_d  = 1'b0;
                    pass_d  = 1'b0;
                    sig_d   = SEED;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            default: state_d = IDLE;
        endcase
        if (abort) begin
            state_d = IDLE;
            sig_d   = SEED;
            cnt_d   = '0;
            done_d  = 1'b0;
            pass_d  = 1'b0;
        end
    end

    // busy is registered from the next state so it tracks RUN/CHECK exactly.
    assign busy_d = (state_d == RUN) || (state_d == CHECK);

    // State and datapath registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            sig_q   <= SEED;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sig_q   <= sig_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
        end
    end

    assign signature = sig_q;
    assign count     = cnt_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;

endmodule

// File: doc/misr_signature_analyzer.md
Name: misr_signature_analyzer

Overview:
- Output-response compactor for LFSR-driven BIST; the receiving end of the test-pattern generator.
- Folds N_PATTERNS circuit-under-test responses into a multiple-input signature register (MISR).
- At the end of the session, compares the signature with a golden value and reports done and pass/fail.
- Sits between the CUT outputs and the BIST controller.

Parameters:
- W, 16, data and signature width (≥2)
- POLY, 16'h100B, feedback tap mask; bit j=1 puts sig[j] into the feedback XOR
- SEED, 0, signature value loaded on reset and on session start
- N_PATTERNS, 64, responses compacted per session (≥1)

Ports:
- clk  in  1  system clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- start  in  1  begin session; honoured in IDLE and DONE only
- abort  in  1  synchronous return to IDLE from any state
- in_valid  in  1  in_data carries a CUT response this cycle
- in_data  in  W  CUT response word
- golden  in  W  expected signature; sampled in CHECK
- signature  out  W  current MISR contents
- count  out  $clog2(N_PATTERNS+1)  responses compacted this session
- busy  out  1  high in RUN and CHECK
- done  out  1  session complete; high in DONE
- pass  out  1  signature==golden; valid while done=1, else 0

Behaviour:
- MISR update when a response is accepted:
  - fb = XOR over j of (sig[j] & POLY[j])
  - sig_next = {fb, sig[W-1:1]} ^ in_data
- Async reset (reset_n=0) sets, immediately and independent of clk:
  - state=IDLE, signature=SEED, count=0, busy=0, done=0, pass=0
- States: IDLE, RUN, CHECK, DONE. busy, done and pass are registered outputs.
- IDLE:
  - signature and count hold.
  - start=1: signature<=SEED, count<=0, go RUN.
- RUN:
  - in_valid=1: signature<=sig_next, count<=count+1.
  - in_valid=0: all hold; stalls are unlimited.
  - If in_valid=1 and count==N_PATTERNS-1: go CHECK at that edge (count becomes N_PATTERNS).
  - start is ignored.
- CHECK (exactly one cycle):
  - in_valid ignored, signature frozen.
  - pass<=(signature==golden), done<=1, go DONE.
- DONE:
  - done=1; pass, signature and count hold.
  - start=1: done<=0, pass<=0, signature<=SEED, count<=0, go RUN.
- Latency: last response clocked in at edge k → CHECK during cycle k..k+1 → done=1 and pass valid after edge k+1.
- abort=1 (any state):
  - go IDLE; busy, done, pass <= 0.
  - signature<=SEED, count<=0.
  - abort beats start in the same cycle.
- Responses with in_valid=1 outside RUN are discarded; no effect on signature or count.
- count never exceeds N_PATTERNS; the signature never wraps count.
- N_PATTERNS=1: a single accepted response moves RUN→CHECK.
- reset_n deassertion is synchronised by the integrator; the block assumes clean release.

Test Plan:
- Post-reset check (W=4, POLY=4'b1001, SEED=0, N_PATTERNS=3): pulse reset_n low mid-RUN → signature=0, count=0, busy=0, done=0, pass=0, state IDLE.
- Pass session (same parameters): start, then responses 4'h1, 4'h0, 4'h0 on consecutive cycles, golden=4'hC.
  - Signature steps 1→8→C.
  - done=1 and pass=1 two edges after the third response.
  - busy high from the edge after start through CHECK.
- Fail session: same stimulus with golden=4'hD → done=1, pass=0, signature=4'hC.
- Stalls: same responses interleaved with 2 in_valid=0 cycles each → identical signature 4'hC; count holds during stalls; done is delayed accordingly.
- Abort: abort after 2 responses → IDLE next edge, signature=0, count=0, busy=0. Then start with abort=1 in the same cycle → stays IDLE.
- Restart and discard: from DONE, start → done and pass clear, count=0. Pulses of in_valid in IDLE or CHECK leave signature unchanged.
